// File: rtl/cmd_scheduler.sv
// Host-side command sequencer for the Knight's Tour link.
// Queues 16-bit commands and feeds them one at a time to RemoteComm.
module cmd_scheduler #(
  parameter int          DEPTH    = 8,
  parameter logic [7:0]  ACK_BYTE = 8'hA5,
  parameter int          TIMEOUT  = 8000000,
  parameter int          TMO_W    = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [15:0]                push_cmd,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovfl,
  input  logic                       run,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic [15:0]                cmd,
  output logic                       snd_cmd,
  input  logic                       cmd_snt,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic                       clr_rx_rdy,
  output logic                       busy,
  output logic [7:0]                 done_cnt,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [7:0]                 last_resp
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SNT,
    WAIT_RESP,
    ERROR
  } state_t;

  state_t state, state_nx;

  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  cnt;
  logic           ovfl_q;

  logic [15:0]    cmd_q, cmd_d;
  logic           snd_q, snd_d;
  logic           clr_q, clr_d;
  logic [7:0]     done_q, done_d;
  logic [1:0]     code_q, code_d;
  logic [7:0]     last_q, last_d;
  logic [TMO_W-1:0] tmo, tmo_d;

  logic pop, push_ok, tmo_hit, is_ack;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign ovfl    = ovfl_q;

  // Flush wins over both sides; a pop frees the slot for a full push.
  assign pop     = (state == IDLE) && run && !empty && !flush;
  assign push_ok = push && !flush && (!full || pop);
  assign tmo_hit = (tmo == TMO_LAST);
  assign is_ack  = (resp == ACK_BYTE);

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wptr] <= push_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      ovfl_q <= 1'b0;
    end else begin
      if (push_ok)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push && full && !pop)
        ovfl_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pop)
          state_nx = WAIT_SNT;
      end
      WAIT_SNT: begin
        if (cmd_snt)
          state_nx = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (resp_rdy)
          state_nx = is_ack ? IDLE : ERROR;
        else if (tmo_hit)
          state_nx = ERROR;
      end
      ERROR: begin
        if (clr_err)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_d  = cmd_q;
    snd_d  = 1'b0;
    clr_d  = 1'b0;
    done_d = done_q;
    code_d = code_q;
    last_d = last_q;
    tmo_d  = tmo;
    unique case (state)
      IDLE: begin
        if (pop) begin
          cmd_d = mem[rptr];
          snd_d = 1'b1;
        end
      end
      WAIT_SNT: begin
        if (cmd_snt)
          tmo_d = '0;
      end
      WAIT_RESP: begin
        tmo_d = tmo + TMO_W'(1);
        if (resp_rdy) begin
          last_d = resp;
          clr_d  = 1'b1;
          if (is_ack)
            done_d = done_q + 8'd1;
          else
            code_d = 2'b01;
        end else if (tmo_hit) begin
          code_d = 2'b10;
        end
      end
      ERROR: begin
        if (clr_err)
          code_d = 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= '0;
      snd_q  <= 1'b0;
      clr_q  <= 1'b0;
      done_q <= '0;
      code_q <= '0;
      last_q <= '0;
      tmo    <= '0;
    end else begin
      cmd_q  <= cmd_d;
      snd_q  <= snd_d;
      clr_q  <= clr_d;
      done_q <= done_d;
      code_q <= code_d;
      last_q <= last_d;
      tmo    <= tmo_d;
    end
  end

  assign cmd        = cmd_q;
  assign snd_cmd    = snd_q;
  assign clr_rx_rdy = clr_q;
  assign done_cnt   = done_q;
  assign err_code   = code_q;
  assign last_resp  = last_q;
  assign err        = (state == ERROR);
  assign busy       = (state == WAIT_SNT) || (state == WAIT_RESP);

endmodule
